fastkdf_out_calc: RTL and testbench
===================================

# fastkdf_out_calc

Final-stage consumer of the BLAKE2s calculation chain in the FastKDF datapath. It accepts the finished A/B buffers and buffer pointer from the last calculation stage over a valid/ready handshake. It produces the KDF output with a multi-cycle byte-lane engine, `out[i] = b[(buf_ptr + i) mod KDF_BUF_SIZE] ^ a[i]`, and presents the result to the downstream consumer over a second valid/ready handshake.

## Interface
Parameters:
- `KDF_BUF_SIZE`, 256: circular B-buffer length in bytes; must be a power of two, 256 or less.
- `INPUT_SIZE`, 64: extra A-buffer bytes; A width is `(KDF_BUF_SIZE+INPUT_SIZE)*8`.
- `KEY_SIZE`, 32: extra B-buffer tail bytes; B width is `(KDF_BUF_SIZE+KEY_SIZE)*8`. Tail bytes are ignored.
- `OUT_LEN`, 32: output length in bytes; must be at most `KDF_BUF_SIZE+INPUT_SIZE`.
- `LANES`, 4: bytes computed per cycle; `OUT_LEN % LANES == 0`.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_vld`, input, 1: upstream data valid.
- `in_rdy`, output, 1: block can accept.
- `a_in`, input, `(KDF_BUF_SIZE+INPUT_SIZE)*8`: A buffer; byte k is `a_in[8k+7:8k]`.
- `b_in`, input, `(KDF_BUF_SIZE+KEY_SIZE)*8`: B buffer, same byte order.
- `buf_ptr_in`, input, 8: B read offset.
- `out_vld`, output, 1: result valid.
- `out_rdy`, input, 1: downstream accepts.
- `kdf_out`, output, `OUT_LEN*8`: result; byte i is `kdf_out[8i+7:8i]`.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- **IDLE**
  - `in_rdy=1`.
  - On `in_vld & in_rdy`: capture `a_in[OUT_LEN*8-1:0]`, `b_in[KDF_BUF_SIZE*8-1:0]` and `buf_ptr_in` into internal registers; clear `lane_cnt`; go to CALC.
- **CALC**
  - Each cycle, compute bytes `i = lane_cnt*LANES + j` for `j = 0..LANES-1`.
  - Write each into the `kdf_out` register byte i.
  - Increment `lane_cnt`. On the write with `lane_cnt == OUT_LEN/LANES-1`, go to DONE.
- **DONE**
  - `out_vld=1` and `kdf_out` is held stable.
  - On `out_rdy`, go to IDLE.
- Index arithmetic:
  - B index is `(buf_ptr + i) & (KDF_BUF_SIZE-1)`, computed in 9 bits and then masked. With the defaults this is a natural 8-bit wrap.
  - A index is i, with no wrap.
- Inputs are sampled only at the acceptance edge. Later changes on `a_in`, `b_in` or `buf_ptr_in` have no effect.
- `in_rdy` and `out_vld` are never both high. There is no input/output overlap, so throughput is one result per `OUT_LEN/LANES + 2` cycles minimum.
- Reset outputs:
  - `in_rdy=1` once `rst_n` is high (combinational from state IDLE).
  - `out_vld=0`.
  - `kdf_out=0`.
  - `lane_cnt=0`.
- Reset asserted mid-CALC or mid-DONE: immediately return to IDLE and zero all registers. A partial result is never presented.

## Timing
- **Acceptance edge:** edge 0, where `in_vld & in_rdy` are both high.
- **CALC writes:** on edges 1 through `OUT_LEN/LANES`; with the defaults that is 8 edges.
- **Result:** `out_vld` rises after edge `OUT_LEN/LANES`, i.e. 8 cycles after acceptance.
- **Completion:** `out_vld` falls on the first edge where `out_rdy` is high.
  - `in_rdy` rises in the same cycle that `out_vld` falls.
  - The next acceptance is possible on the following edge.
- **Held output:** `kdf_out` keeps its value after leaving DONE until the next CALC write.
- **Combinational paths:**
  - `in_rdy` and `out_vld` are pure state decodes, with no path from `in_vld` or `out_rdy`.
  - `out_rdy` is ignored outside DONE, and `in_vld` is ignored outside IDLE.

## Structure
- Shared package `fastkdf_pkg` holds:
  - localparams for the default buffer sizes;
  - the `fsm_t` enum `{IDLE, CALC, DONE}`;
  - a byte-extract function (buffer, index → 8-bit).
- Sub-module `fastkdf_lane_xor` (one instance per lane, via generate) contains:
  - the B byte mux over `KDF_BUF_SIZE` and the A byte mux over `OUT_LEN`;
  - the pointer add/mask;
  - the XOR.
- The top level holds the FSM, `lane_cnt`, the capture registers and the output register.

## Test plan
1. Basic read: `a=0`, B byte k = k, `buf_ptr=0`. Expect `kdf_out` bytes 0..31 = 0x00..0x1F, with `out_vld` 8 cycles after acceptance.
2. Pointer wrap: same B, `buf_ptr=240`. Expect bytes = 0xF0..0xFF followed by 0x00..0x0F, confirming B tail bytes 256..287 are never used.
3. XOR path: A bytes = 0xFF, B byte k = k, `buf_ptr=0x10`. Expect byte i = `~(0x10+i)`.
4. Backpressure: hold `out_rdy=0` for 5 cycles in DONE. Expect `kdf_out` and `out_vld` stable, `in_rdy=0` and a new `in_vld` ignored. Then release and expect `in_rdy` high the next cycle.
5. Reset mid-CALC: assert `rst_n=0` at CALC cycle 4. Expect `out_vld=0`, `kdf_out=0` and state IDLE immediately. A following transaction completes correctly.
6. Back-to-back: `in_vld` held high with two distinct payloads. Expect the second accepted on the cycle `in_rdy` returns, with results matching the model in order. Also change `a_in` during CALC and expect no effect on the result.

Source files
------------

// File: rtl/fastkdf_pkg.sv
// Shared sizes, FSM encoding and byte-extract helper for the FastKDF output stage.
package fastkdf_pkg;

    localparam int DEF_KDF_BUF_SIZE = 256;
    localparam int DEF_INPUT_SIZE   = 64;
    localparam int DEF_KEY_SIZE     = 32;
    localparam int DEF_OUT_LEN      = 32;
    localparam int DEF_LANES        = 4;

    // Widest buffer any lane mux has to index; a 9-bit byte index covers it.
    localparam int MAX_BUF_BYTES = 512;
    localparam int MAX_BUF_BITS  = MAX_BUF_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_t;

    function automatic logic [7:0] get_byte(input logic [MAX_BUF_BITS-1:0] buf_v,
                                            input logic [8:0]              idx);
        return buf_v[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/fastkdf_lane_xor.sv
// One byte lane: circular B read at (buf_ptr + i), linear A read at i, XORed together.
module fastkdf_lane_xor
    import fastkdf_pkg::*;
#(
    parameter int KDF_BUF_SIZE = DEF_KDF_BUF_SIZE,
    parameter int OUT_LEN      = DEF_OUT_LEN
) (
    input  logic [OUT_LEN*8-1:0]      a_buf,
    input  logic [KDF_BUF_SIZE*8-1:0] b_buf,
    input  logic [7:0]                buf_ptr,
    input  logic [8:0]                byte_idx,
    output logic [7:0]                byte_out
);

    localparam logic [8:0] B_MASK = 9'(KDF_BUF_SIZE - 1);

    logic [8:0]              b_idx_s;
    logic [MAX_BUF_BITS-1:0] a_ext_s;
    logic [MAX_BUF_BITS-1:0] b_ext_s;

    // Power-of-two buffer length lets the modulo collapse to a mask.
    assign b_idx_s  = ({1'b0, buf_ptr} + byte_idx) & B_MASK;
    assign a_ext_s  = MAX_BUF_BITS'(a_buf);
    assign b_ext_s  = MAX_BUF_BITS'(b_buf);
    assign byte_out = get_byte(a_ext_s, byte_idx) ^ get_byte(b_ext_s, b_idx_s);

endmodule

// File: rtl/fastkdf_out_calc.sv
// FastKDF final stage: captures A/B/pointer, builds the KDF output LANES bytes per cycle,
// and holds it for a valid/ready consumer.
module fastkdf_out_calc
    import fastkdf_pkg::*;
#(
    parameter int KDF_BUF_SIZE = DEF_KDF_BUF_SIZE,
    parameter int INPUT_SIZE   = DEF_INPUT_SIZE,
    parameter int KEY_SIZE     = DEF_KEY_SIZE,
    parameter int OUT_LEN      = DEF_OUT_LEN,
    parameter int LANES        = DEF_LANES
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_vld,
    output logic                                  in_rdy,
    input  logic [(KDF_BUF_SIZE+INPUT_SIZE)*8-1:0] a_in,
    input  logic [(KDF_BUF_SIZE+KEY_SIZE)*8-1:0]   b_in,
    input  logic [7:0]                             buf_ptr_in,
    output logic                                  out_vld,
    input  logic                                  out_rdy,
    output logic [OUT_LEN*8-1:0]                   kdf_out
);

    localparam int A_W    = (KDF_BUF_SIZE + INPUT_SIZE) * 8;
    localparam int B_W    = (KDF_BUF_SIZE + KEY_SIZE) * 8;
    localparam int STEPS  = OUT_LEN / LANES;
    localparam int CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int WORD_W = LANES * 8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    fsm_t                      state_r;
    fsm_t                      state_next_s;
    logic [CNT_W-1:0]          lane_cnt_r;
    logic [OUT_LEN*8-1:0]      a_cap_r;
    logic [KDF_BUF_SIZE*8-1:0] b_cap_r;
    logic [7:0]                buf_ptr_r;
    logic [WORD_W-1:0]         kdf_word_r [STEPS];
    logic [WORD_W-1:0]         lane_word_s;
    logic                      accept_s;
    logic                      unused_s;

    // Upper A bytes and the B key tail never contribute to the output.
    assign unused_s = ^{a_in[A_W-1:OUT_LEN*8], b_in[B_W-1:KDF_BUF_SIZE*8]};
    assign accept_s = in_vld & in_rdy;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode; in_vld only matters in IDLE, out_rdy only in DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_vld) state_next_s = CALC;
                else        state_next_s = IDLE;
            end
            CALC: begin
                if (lane_cnt_r == CNT_LAST) state_next_s = DONE;
                else                        state_next_s = CALC;
            end
            DONE: begin
                if (out_rdy) state_next_s = IDLE;
                else         state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes.
    always_comb begin
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state_r)
            IDLE: in_rdy  = 1'b1;
            DONE: out_vld = 1'b1;
            default: begin
                in_rdy  = 1'b0;
                out_vld = 1'b0;
            end
        endcase
    end

    // Capture registers, lane counter and result words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cap_r    <= {(OUT_LEN*8){1'b0}};
            b_cap_r    <= {(KDF_BUF_SIZE*8){1'b0}};
            buf_ptr_r  <= 8'h00;
            lane_cnt_r <= CNT_ZERO;
            for (int w = 0; w < STEPS; w++) begin
                kdf_word_r[w] <= {WORD_W{1'b0}};
            end
        end else if (accept_s) begin
            a_cap_r    <= a_in[OUT_LEN*8-1:0];
            b_cap_r    <= b_in[KDF_BUF_SIZE*8-1:0];
            buf_ptr_r  <= buf_ptr_in;
            lane_cnt_r <= CNT_ZERO;
        end else if (state_r == CALC) begin
            kdf_word_r[lane_cnt_r] <= lane_word_s;
            lane_cnt_r             <= lane_cnt_r + CNT_ONE;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [8:0] byte_idx_s;

        assign byte_idx_s = 9'(int'(lane_cnt_r) * LANES + g);

        fastkdf_lane_xor #(
            .KDF_BUF_SIZE(KDF_BUF_SIZE),
            .OUT_LEN     (OUT_LEN)
        ) u_lane (
            .a_buf   (a_cap_r),
            .b_buf   (b_cap_r),
            .buf_ptr (buf_ptr_r),
            .byte_idx(byte_idx_s),
            .byte_out(lane_word_s[g*8 +: 8])
        );
    end

    for (genvar w = 0; w < STEPS; w++) begin : g_out
        assign kdf_out[w*WORD_W +: WORD_W] = kdf_word_r[w];
    end

endmodule

// File: tb/tb_fastkdf_out_calc.sv
// Scoreboard bench for fastkdf_out_calc: directed transactions, queue-based result checking.
module tb_fastkdf_out_calc;

    localparam int KBS = 256;
    localparam int INS = 64;
    localparam int KS  = 32;
    localparam int OL  = 32;
    localparam int LN  = 4;
    localparam int AW  = (KBS + INS) * 8;
    localparam int BW  = (KBS + KS) * 8;
    localparam int OW  = OL * 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic          in_rdy;
    logic [AW-1:0] a_in;
    logic [BW-1:0] b_in;
    logic [7:0]    buf_ptr_in;
    logic          out_vld;
    logic          out_rdy;
    logic [OW-1:0] kdf_out;

    logic [OW-1:0] sb_q[$];
    int            checks = 0;
    int            passes = 0;

    always #5 clk = ~clk;

    fastkdf_out_calc #(
        .KDF_BUF_SIZE(KBS), .INPUT_SIZE(INS), .KEY_SIZE(KS), .OUT_LEN(OL), .LANES(LN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .a_in      (a_in),
        .b_in      (b_in),
        .buf_ptr_in(buf_ptr_in),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .kdf_out   (kdf_out)
    );

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, OW'(act), OW'(exp));
    endtask

    // Hand-derived expectation: byte i = start+i (mod 256), optionally inverted.
    function automatic logic [OW-1:0] ramp(input int start, input bit inv);
        logic [OW-1:0] r;
        logic [7:0]    v;
        r = '0;
        for (int i = 0; i < OL; i++) begin
            v = 8'(start + i);
            r[8*i +: 8] = inv ? ~v : v;
        end
        return r;
    endfunction

    // B byte k = k in the circular part, 0xEE in the key tail.
    function automatic logic [BW-1:0] b_ramp();
        logic [BW-1:0] b;
        for (int k = 0; k < BW/8; k++) b[8*k +: 8] = (k < KBS) ? 8'(k) : 8'hEE;
        return b;
    endfunction

    function automatic logic [OW-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                            input int ptr);
        logic [OW-1:0] r;
        for (int i = 0; i < OL; i++) r[8*i +: 8] = a[8*i +: 8] ^ b[8*((ptr + i) % KBS) +: 8];
        return r;
    endfunction

    // Monitor: every completed output handshake is compared against the queue head.
    always @(negedge clk) begin
        if (out_vld && out_rdy) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected: actual %h required no output", kdf_out);
            end else begin
                check("scoreboard", kdf_out, sb_q.pop_front());
            end
        end
    end

    task automatic accept(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [7:0] p,
                          input bit push, input logic [OW-1:0] exp);
        int n;
        n = 0;
        a_in = a; b_in = b; buf_ptr_in = p; in_vld = 1'b1;
        @(negedge clk);
        while (!in_rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("accept_timeout", OW'(n), OW'(0));
        @(posedge clk);
        if (push) sb_q.push_back(exp);
        #1;
    endtask

    task automatic wait_done(input string name);
        int e;
        e = 0;
        do begin
            @(posedge clk);
            e++;
            #1;
        end while (!out_vld && e < 40);
        check(name, OW'(e), OW'(8));
    endtask

    task automatic finish_txn();
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        check_bit("in_rdy_after_done", in_rdy, 1'b1);
        check_bit("out_vld_after_done", out_vld, 1'b0);
    endtask

    task automatic run(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [7:0] p,
                       input logic [OW-1:0] exp);
        accept(a, b, p, 1'b1, exp);
        in_vld = 1'b0;
        wait_done("latency");
        finish_txn();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a1, a2, aj;
        logic [BW-1:0] b2;
        logic [OW-1:0] e4, e6;
        int            e;

        rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
        a_in = '0; b_in = '0; buf_ptr_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_kdf_out", kdf_out, '0);
        check_bit("reset_out_vld", out_vld, 1'b0);
        rst_n = 1'b1;
        #1;
        check_bit("reset_in_rdy", in_rdy, 1'b1);

        // 1-3: basic read, pointer wrap (tail untouched), XOR path
        run('0, b_ramp(), 8'd0, ramp(0, 1'b0));
        run('0, b_ramp(), 8'd240, ramp(240, 1'b0));
        run({AW{1'b1}}, b_ramp(), 8'h10, ramp(16, 1'b1));

        // 4: backpressure in DONE with a competing input that must be ignored
        e4 = ramp(5, 1'b0);
        accept('0, b_ramp(), 8'd5, 1'b1, e4);
        in_vld = 1'b0;
        wait_done("bp_latency");
        for (int i = 0; i < AW/8; i++) aj[8*i +: 8] = 8'(i * 7 + 3);
        a_in = aj; buf_ptr_in = 8'h33; in_vld = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_kdf_stable", kdf_out, e4);
            check_bit("bp_out_vld", out_vld, 1'b1);
            check_bit("bp_in_rdy", in_rdy, 1'b0);
        end
        in_vld = 1'b0;
        finish_txn();

        // 5: reset in the middle of CALC, then a clean transaction
        accept(aj, b_ramp(), 8'd9, 1'b0, '0);
        in_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("rst_mid_out_vld", out_vld, 1'b0);
        check("rst_mid_kdf_out", kdf_out, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_bit("rst_mid_in_rdy", in_rdy, 1'b1);
        run(aj, b_ramp(), 8'd250, model(aj, b_ramp(), 250));

        // 6: back-to-back with inputs changing during CALC
        for (int i = 0; i < AW/8; i++) a1[8*i +: 8] = 8'(3 * i + 1);
        a2 = {(AW/8){8'h5A}};
        for (int k = 0; k < BW/8; k++) b2[8*k +: 8] = 8'(255 - k);
        accept(a1, b_ramp(), 8'd200, 1'b1, model(a1, b_ramp(), 200));
        a_in = a2; b_in = b2; buf_ptr_in = 8'd7; out_rdy = 1'b1;
        e = 0;
        do begin
            @(posedge clk);
            e++;
            #1;
        end while (!in_rdy && e < 40);
        check("b2b_in_rdy_return", OW'(e), OW'(9));
        e6 = model(a2, b2, 7);
        @(posedge clk);
        sb_q.push_back(e6);
        #1;
        in_vld = 1'b0;
        wait_done("b2b_latency");
        finish_txn();

        repeat (3) @(posedge clk);
        check("sb_drain", OW'(sb_q.size()), OW'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
